// File: rtl/alu_pkg.sv
// Shared definitions for the small serial ALU blocks: FSM state type and
// the default operand width.
package alu_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder; the only arithmetic element of the serial subtractor.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  // Sum and majority carry-out
  always_comb begin
    o_sum  = i_a ^ i_b ^ i_cin;
    o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);
  end

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: a - b computed LSB first as a + ~b + 1 through a
// single full adder, one bit per clock, WIDTH clocks per operation.
//
// Handshake: i_start is a request sampled only while idle; the operands are
// captured on the accepting edge. o_busy is high for the WIDTH processing
// cycles, then o_done pulses for one cycle while o_result/o_borrow/o_overflow
// present the new values. Those outputs hold until the next completion.
// The internal FSM state is the register 'state' (type alu_pkg::state_t).
module serial_sub
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_borrow,
  output logic             o_overflow
);

  // Counter holds 0..WIDTH without wrapping.
  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;     // minuend, shifted right so bit 0 is current
  logic [WIDTH-1:0] b_sh;     // subtrahend, shifted likewise
  logic             a_msb;    // sign bits kept for the overflow decision
  logic             b_msb;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;      // difference bits enter at the MSB end
  logic [WIDTH-1:0] acc_next;
  logic             fa_sum;
  logic             fa_cout;
  logic             last_bit;

  full_adder u_fa (
    .i_a   (a_sh[0]),
    .i_b   (~b_sh[0]),
    .i_cin (carry),
    .o_sum (fa_sum),
    .o_cout(fa_cout)
  );

  // Next accumulator value and last-step detection
  always_comb begin
    acc_next = WIDTH'({fa_sum, acc} >> 1);
    last_bit = (cnt == CW'(WIDTH - 1));
  end

  // Control FSM with datapath registers and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      a_sh       <= '0;
      b_sh       <= '0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      carry      <= 1'b0;
      cnt        <= '0;
      acc        <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_result   <= '0;
      o_borrow   <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            a_sh   <= i_a;
            b_sh   <= i_b;
            a_msb  <= i_a[WIDTH-1];
            b_msb  <= i_b[WIDTH-1];
            carry  <= 1'b1;
            cnt    <= '0;
            o_busy <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          carry <= fa_cout;
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          acc   <= acc_next;
          cnt   <= cnt + CW'(1);
          if (last_bit) begin
            // The final full-adder sum bit is the result sign bit.
            o_result   <= acc_next;
            o_borrow   <= ~fa_cout;
            o_overflow <= (a_msb ^ b_msb) & (fa_sum ^ a_msb);
            o_busy     <= 1'b0;
            o_done     <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          o_done <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          o_busy <= 1'b0;
          o_done <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Testbench for serial_sub: an 8-bit instance for directed, random,
// back-to-back and reset scenarios, and a 2-bit instance run exhaustively.
module tb_serial_sub;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 8-bit instance
  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, bor8, ovf8;
  logic [7:0] res8;

  // 2-bit instance
  logic       start2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       busy2, done2, bor2, ovf2;
  logic [1:0] res2;

  serial_sub #(.WIDTH(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_start(start8), .i_a(a8), .i_b(b8),
    .o_busy(busy8), .o_done(done8), .o_result(res8),
    .o_borrow(bor8), .o_overflow(ovf8)
  );

  serial_sub #(.WIDTH(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_start(start2), .i_a(a2), .i_b(b2),
    .o_busy(busy2), .o_done(done2), .o_result(res2),
    .o_borrow(bor2), .o_overflow(ovf2)
  );

  int err_cnt = 0;
  int chk_cnt = 0;

  // scoreboard queue: {result, borrow, overflow}
  logic [9:0] exp_q[$];

  // ---------------- reference model ----------------
  // Plain integer arithmetic on the operands as unsigned and signed values.
  function automatic void ref_sub(input int w, input int a, input int b,
                                  output int diff, output logic bor,
                                  output logic ovf);
    int m, sa, sb, d;
    m    = 1 << w;
    diff = (a - b + m) % m;
    bor  = (a < b);
    sa   = (a >= m / 2) ? a - m : a;
    sb   = (b >= m / 2) ? b - m : b;
    d    = sa - sb;
    ovf  = (d > m / 2 - 1) || (d < -(m / 2));
  endfunction

  // ---------------- driver tasks ----------------
  // Start one 8-bit operation; scramble operands while it runs; report
  // results, latency in edges from acceptance (-1 on timeout), busy cycles,
  // and o_done one cycle after the pulse.
  task automatic do_op8(input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] res, output logic bor,
                        output logic ovf, output int lat, output int busy_n,
                        output logic done_after);
    @(negedge clk);
    start8 = 1'b1; a8 = a; b8 = b;
    @(posedge clk); #1;
    start8 = 1'b0;
    busy_n = int'(busy8);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      a8 = 8'($urandom); b8 = 8'($urandom);
      @(posedge clk); #1;
      if (done8) begin
        lat = k;
        break;
      end
      busy_n += int'(busy8);
    end
    res = res8; bor = bor8; ovf = ovf8;
    @(posedge clk); #1;
    done_after = done8;
  endtask

  task automatic do_op2(input logic [1:0] a, input logic [1:0] b,
                        output logic [1:0] res, output logic bor,
                        output logic ovf, output int lat);
    @(negedge clk);
    start2 = 1'b1; a2 = a; b2 = b;
    @(posedge clk); #1;
    start2 = 1'b0;
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      a2 = 2'($urandom); b2 = 2'($urandom);
      @(posedge clk); #1;
      if (done2) begin
        lat = k;
        break;
      end
    end
    res = res2; bor = bor2; ovf = ovf2;
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    // reset and start asserted together: reset wins
    @(negedge clk);
    rst = 1'b1; start8 = 1'b1; a8 = 8'd9; b8 = 8'd4;
    repeat (2) @(posedge clk);
    #1;
    chk_cnt++;
    if ({busy8, done8, res8, bor8, ovf8} !== 12'h000) begin
      err_cnt++;
      $display("FAIL reset_outputs: got %0h expected 0",
               {busy8, done8, res8, bor8, ovf8});
    end
    @(negedge clk);
    rst = 1'b0; start8 = 1'b0;
    @(posedge clk); #1;
    chk_cnt++;
    if (busy8 !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_idle_busy: got %0b expected 0", busy8);
    end
  endtask

  task automatic test_directed();
    logic [7:0] ta[4] = '{8'd100, 8'd5, 8'h80, 8'h7F};
    logic [7:0] tb[4] = '{8'd58,  8'd7, 8'h01, 8'hFF};
    logic [7:0] er[4] = '{8'd42,  8'hFE, 8'h7F, 8'h80};
    logic       eb[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic       eo[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] res;
    logic bor, ovf, dn_after;
    int lat, bn;
    for (int i = 0; i < 4; i++) begin
      do_op8(ta[i], tb[i], res, bor, ovf, lat, bn, dn_after);
      chk_cnt++;
      if ({res, bor, ovf} !== {er[i], eb[i], eo[i]}) begin
        err_cnt++;
        $display("FAIL directed_%0d: got res=%0h bor=%0b ovf=%0b expected res=%0h bor=%0b ovf=%0b",
                 i, res, bor, ovf, er[i], eb[i], eo[i]);
      end
      chk_cnt++;
      if (lat !== 8) begin
        err_cnt++;
        $display("FAIL directed_latency_%0d: got %0d expected 8", i, lat);
      end
      chk_cnt++;
      if (bn !== 8) begin
        err_cnt++;
        $display("FAIL directed_busy_cycles_%0d: got %0d expected 8", i, bn);
      end
      chk_cnt++;
      if (dn_after !== 1'b0) begin
        err_cnt++;
        $display("FAIL directed_done_width_%0d: got %0b expected 0", i, dn_after);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] a, b, res;
    logic bor, ovf, dn_after, eb, eov;
    logic [9:0] exp_v;
    int lat, bn, diff;
    for (int i = 0; i < 25; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      ref_sub(8, int'(a), int'(b), diff, eb, eov);
      exp_q.push_back({8'(diff), eb, eov});
      do_op8(a, b, res, bor, ovf, lat, bn, dn_after);
      exp_v = exp_q.pop_front();
      chk_cnt++;
      if ({res, bor, ovf} !== exp_v || lat !== 8) begin
        err_cnt++;
        $display("FAIL random_%0d (%0h-%0h): got %0h lat=%0d expected %0h lat=8",
                 i, a, b, {res, bor, ovf}, lat, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] opa[40], opb[40];
    logic exp_busy, exp_done, eb, eov;
    int diff;
    repeat (3) @(posedge clk);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      start8 = 1'b1;
      a8 = 8'($urandom); b8 = 8'($urandom);
      opa[n] = a8; opb[n] = b8;
      @(posedge clk); #1;
      exp_busy = ((n % 10) < 8);
      exp_done = ((n % 10) == 8);
      chk_cnt++;
      if (busy8 !== exp_busy || done8 !== exp_done) begin
        err_cnt++;
        $display("FAIL b2b_ctrl_edge%0d: got busy=%0b done=%0b expected busy=%0b done=%0b",
                 n, busy8, done8, exp_busy, exp_done);
      end
      if (exp_done) begin
        ref_sub(8, int'(opa[n-8]), int'(opb[n-8]), diff, eb, eov);
        chk_cnt++;
        if ({res8, bor8, ovf8} !== {8'(diff), eb, eov}) begin
          err_cnt++;
          $display("FAIL b2b_result_edge%0d: got %0h expected %0h",
                   n, {res8, bor8, ovf8}, {8'(diff), eb, eov});
        end
      end
    end
    @(negedge clk);
    start8 = 1'b0;
    repeat (12) @(posedge clk);
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] res;
    logic bor, ovf, dn_after, seen_done;
    int lat, bn;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'd200; b8 = 8'd17;
    @(posedge clk); #1;          // acceptance edge E
    start8 = 1'b0;
    repeat (3) @(posedge clk);   // E+1..E+3
    @(negedge clk);
    rst = 1'b1;                  // during 4th RUN cycle
    @(posedge clk); #1;
    chk_cnt++;
    if ({busy8, done8, res8, bor8, ovf8} !== 12'h000) begin
      err_cnt++;
      $display("FAIL midrun_reset_outputs: got %0h expected 0",
               {busy8, done8, res8, bor8, ovf8});
    end
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done8) seen_done = 1'b1;
    end
    chk_cnt++;
    if (seen_done !== 1'b0) begin
      err_cnt++;
      $display("FAIL midrun_no_done: got %0b expected 0", seen_done);
    end
    do_op8(8'd3, 8'd3, res, bor, ovf, lat, bn, dn_after);
    chk_cnt++;
    if ({res, bor, ovf} !== 10'h000 || lat !== 8) begin
      err_cnt++;
      $display("FAIL after_reset_3_minus_3: got %0h lat=%0d expected 0 lat=8",
               {res, bor, ovf}, lat);
    end
  endtask

  task automatic test_width2_exhaustive();
    logic [1:0] res;
    logic bor, ovf, eb, eov;
    int lat, diff;
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        ref_sub(2, a, b, diff, eb, eov);
        do_op2(2'(a), 2'(b), res, bor, ovf, lat);
        chk_cnt++;
        if ({res, bor, ovf} !== {2'(diff), eb, eov} || lat !== 2) begin
          err_cnt++;
          $display("FAIL w2_%0d_minus_%0d: got %0h lat=%0d expected %0h lat=2",
                   a, b, {res, bor, ovf}, lat, {2'(diff), eb, eov});
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_run();
    test_width2_exhaustive();
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/serial_sub.md
SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, operand and result width in bits; legal range 2..32.
REQ-002 The module SHALL have port i_clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 The module SHALL have port i_rst  input  1  reset, synchronous and active-high.
REQ-004 The module SHALL have port i_start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 The module SHALL have port i_a  input  WIDTH  minuend; captured when i_start is accepted.
REQ-006 The module SHALL have port i_b  input  WIDTH  subtrahend; captured when i_start is accepted.
REQ-007 The module SHALL have port o_busy  output  1  high while bits are being processed (RUN).
REQ-008 The module SHALL have port o_done  output  1  single-cycle completion pulse.
REQ-009 The module SHALL have port o_result  output  WIDTH  difference a-b modulo 2^WIDTH.
REQ-010 The module SHALL have port o_borrow  output  1  unsigned borrow, high when a<b.
REQ-011 The module SHALL have port o_overflow  output  1  two's-complement signed overflow of a-b.

Function
REQ-012 The block SHALL be a three-state FSM: IDLE, RUN, DONE.
REQ-013 In IDLE with i_start=1 at edge E, the block SHALL capture i_a and i_b, set the carry register to 1, clear the bit counter, and enter RUN.
REQ-014 In RUN, each edge SHALL process one bit, LSB first: difference bit = a[k] XOR NOT b[k] XOR carry; carry updated by full-adder carry-out.
REQ-015 Difference bits SHALL shift into an internal result register from the MSB end, so the word is aligned after WIDTH steps.
REQ-016 After the WIDTH-th RUN edge (edge E+WIDTH), the block SHALL enter DONE.
REQ-017 After edge E+WIDTH, o_result, o_borrow and o_overflow SHALL update together.
REQ-018 o_borrow SHALL equal NOT final carry.
REQ-019 o_overflow SHALL be (a[MSB]!=b[MSB]) AND (result[MSB]!=a[MSB]).
REQ-020 o_done SHALL be high for exactly the cycle between edges E+WIDTH and E+WIDTH+1; at edge E+WIDTH+1 the FSM SHALL return to IDLE.
REQ-021 o_busy SHALL be high exactly while in RUN (WIDTH cycles per operation).
REQ-022 i_start SHALL be ignored in RUN and DONE; minimum back-to-back start spacing is WIDTH+2 edges.
REQ-023 Changes on i_a/i_b after capture SHALL NOT affect the operation in flight.
REQ-024 o_result, o_borrow and o_overflow SHALL hold their last completed values until the next completion, never exposing partial results.
REQ-025 The bit counter SHALL be wide enough to count to WIDTH without wrap; it SHALL never index beyond bit WIDTH-1.

Reset
REQ-026 With i_rst=1 at any edge, including mid-RUN, the block SHALL enter IDLE.
REQ-027 On reset, o_busy, o_done, o_result, o_borrow, o_overflow, the carry register and the counter SHALL be 0.
REQ-028 An operation aborted by reset SHALL produce no o_done pulse.
REQ-029 i_rst SHALL take priority over i_start on the same edge.

Structure
REQ-030 The shared package alu_pkg SHALL hold the FSM state type (IDLE/RUN/DONE) and the default width constant.
REQ-031 The per-bit arithmetic SHALL use one instance of the existing full_adder sub-module, with i_b driven by the inverted subtrahend bit and i_cin by the carry register.
REQ-032 The block SHALL contain no other arithmetic; the result-shift, counter and FSM are local registers.

Verification (WIDTH=8)
REQ-033 Check 100-58: the bench SHALL see o_result=42, o_borrow=0, o_overflow=0, with o_done exactly 8 edges after acceptance and o_busy high 8 cycles.
REQ-034 Check 5-7: the bench SHALL see o_result=8'hFE, o_borrow=1, o_overflow=0.
REQ-035 Check 8'h80-8'h01: the bench SHALL see o_result=8'h7F, o_borrow=0, o_overflow=1; check 8'h7F-8'hFF: o_result=8'h80, o_borrow=1, o_overflow=1.
REQ-036 With i_start held high and i_a/i_b toggled every cycle, the bench SHALL see acceptances spaced 10 edges apart and each result matching the operands at the acceptance edge.
REQ-037 Assert i_rst during the 4th RUN cycle: all outputs SHALL be 0 next cycle with no o_done; a following start of 3-3 SHALL yield 0 with o_borrow=0.
REQ-038 With WIDTH=2, all 16 operand pairs SHALL be run exhaustively against a reference model.
